// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss handler.
//   state_t        : fill/store controller states
//   BLOCK_WORDS    : 16-bit words per cache block (counters are 3 bits wide)
//   MEM_LAT        : cycles from read request to mem_rvalid
//   TAG_HI/TAG_LO  : byte-address field holding the block base
//   WORD_HI/WORD_LO: byte-address field holding the word offset in a block
//   block_base()   : clears the offset bits of a byte address
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int MEM_LAT     = 4;
    localparam int CNT_W       = 3;

    localparam int TAG_HI  = 15;
    localparam int TAG_LO  = 4;
    localparam int WORD_HI = 3;
    localparam int WORD_LO = 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        TAG       = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[TAG_HI:TAG_LO], {TAG_LO{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Fixed-priority select of the next memory transaction while the miss
// handler is idle: D-side load miss, then write-through store, then I-side miss.
//   d_miss, d_wr_req, i_miss : pending requests
//   grant_d_miss, grant_d_wr, grant_i_miss : one-hot (or all-zero) grant
module mem_req_arbiter (
    input  logic d_miss,
    input  logic d_wr_req,
    input  logic i_miss,
    output logic grant_d_miss,
    output logic grant_d_wr,
    output logic grant_i_miss
);

    assign grant_d_miss = d_miss;
    assign grant_d_wr   = ~d_miss & d_wr_req;
    assign grant_i_miss = ~d_miss & ~d_wr_req & i_miss;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss handler between the I/D caches and the shared pipelined main memory.
// Fetches 8-word blocks on a cache miss, streams them into the cache data
// array, writes the tag, and forwards write-through stores.
//   clk, rst                         : clock, async active-high reset
//   i_miss/_addr, d_miss/_addr       : miss requests, held until the tag write
//   d_wr_req/_addr/_data, d_wr_done  : write-through store handshake
//   fetch_stall, mem_stall           : pipeline stalls (combinational)
//   mem_en/wr/addr/wdata, mem_rvalid/rdata : main memory port
//   fill_we_i/d, fill_word/data/base : cache data-array write port
//   tag_we_i/d                       : tag write + valid set
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              fetch_stall,
    output logic              mem_stall,
    output logic              d_wr_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic [CNT_W-1:0]  fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_base,
    output logic              tag_we_i,
    output logic              tag_we_d
);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    req_cnt_reg, req_cnt_next;
    logic [CNT_W-1:0]    rsp_cnt_reg, rsp_cnt_next;
    logic                side_d_reg, side_d_next;   // 1 = filling the D-cache
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic                rsp_ok;

    logic grant_d_miss, grant_d_wr, grant_i_miss;

    mem_req_arbiter u_arb (
        .d_miss       (d_miss),
        .d_wr_req     (d_wr_req),
        .i_miss       (i_miss),
        .grant_d_miss (grant_d_miss),
        .grant_d_wr   (grant_d_wr),
        .grant_i_miss (grant_i_miss)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            req_cnt_reg <= '0;
            rsp_cnt_reg <= '0;
            side_d_reg  <= 1'b0;
            base_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            req_cnt_reg <= req_cnt_next;
            rsp_cnt_reg <= rsp_cnt_next;
            side_d_reg  <= side_d_next;
            base_reg    <= base_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        req_cnt_next = req_cnt_reg;
        rsp_cnt_next = rsp_cnt_reg;
        side_d_next  = side_d_reg;
        base_next    = base_reg;
        rsp_ok       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        d_wr_done    = 1'b0;
        fill_we_i    = 1'b0;
        fill_we_d    = 1'b0;
        fill_word    = '0;
        fill_data    = '0;
        tag_we_i     = 1'b0;
        tag_we_d     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_d_miss) begin
                    state_next   = FILL_REQ;
                    side_d_next  = 1'b1;
                    base_next    = block_base(d_miss_addr);
                    req_cnt_next = '0;
                    rsp_cnt_next = '0;
                end else if (grant_d_wr) begin
                    state_next = WRITE;
                end else if (grant_i_miss) begin
                    state_next   = FILL_REQ;
                    side_d_next  = 1'b0;
                    base_next    = block_base(i_miss_addr);
                    req_cnt_next = '0;
                    rsp_cnt_next = '0;
                end
            end
            WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_wr_addr;
                mem_wdata  = d_wr_data;
                d_wr_done  = 1'b1;
                state_next = IDLE;
            end
            FILL_REQ: begin
                mem_en       = 1'b1;
                mem_addr     = base_reg + {{(ADDR_W-CNT_W-1){1'b0}}, req_cnt_reg, 1'b0};
                req_cnt_next = req_cnt_reg + 1'b1;
                // Responses overlap the tail of the request burst.
                rsp_ok       = mem_rvalid;
                if (req_cnt_reg == LAST_WORD) begin
                    state_next = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                rsp_ok = mem_rvalid;
                if (mem_rvalid && rsp_cnt_reg == LAST_WORD) begin
                    state_next = TAG;
                end
            end
            TAG: begin
                tag_we_i   = ~side_d_reg;
                tag_we_d   = side_d_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (rsp_ok) begin
            fill_we_i    = ~side_d_reg;
            fill_we_d    = side_d_reg;
            fill_word    = rsp_cnt_reg;
            fill_data    = mem_rdata;
            rsp_cnt_next = rsp_cnt_reg + 1'b1;
        end
    end

    assign fill_base   = base_reg;
    assign fetch_stall = i_miss & ~tag_we_i;
    assign mem_stall   = (d_miss & ~tag_we_d) | (d_wr_req & ~d_wr_done);

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        fetch_stall, mem_stall, d_wr_done;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, fill_base;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .fetch_stall(fetch_stall), .mem_stall(mem_stall), .d_wr_done(d_wr_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d), .fill_word(fill_word),
        .fill_data(fill_data), .fill_base(fill_base),
        .tag_we_i(tag_we_i), .tag_we_d(tag_we_d)
    );

    // Pipelined memory: read data (word @A = A) returns MEM_LAT cycles after
    // the request. Not reset, so in-flight reads survive a controller reset.
    logic [MEM_LAT-1:0] p_v = '0;
    logic [15:0]        p_a [MEM_LAT];
    always @(posedge clk) begin
        p_v <= {p_v[MEM_LAT-2:0], mem_en & ~mem_wr};
        p_a[0] <= mem_addr;
        for (int k = 1; k < MEM_LAT; k++) p_a[k] <= p_a[k-1];
    end
    assign mem_rvalid = p_v[MEM_LAT-1];
    assign mem_rdata  = p_v[MEM_LAT-1] ? p_a[MEM_LAT-1] : 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle capture of DUT outputs, cycle 0 = first cycle after the
    // request that starts the scenario.
    localparam int NC = 40;
    bit          c_en[NC], c_wr[NC], c_done[NC], c_fs[NC], c_ms[NC];
    bit          c_fwi[NC], c_fwd[NC], c_twi[NC], c_twd[NC];
    logic [15:0] c_addr[NC], c_wdata[NC], c_fdata[NC];
    logic [2:0]  c_fword[NC];

    int act_drop_d, act_rst, act_raise_d, act_raise_wr;
    bit auto_i;

    task automatic capture(input int n);
        bit pend_d = 0, pend_i = 0, pend_wr = 0;
        for (int c = 0; c < n; c++) begin
            // The cache hits once its tag is written, so the miss drops.
            if (pend_d) d_miss = 1'b0;
            if (pend_i) i_miss = 1'b0;
            if (pend_wr) d_wr_req = 1'b0;
            if (c == act_drop_d) d_miss = 1'b0;
            if (c == act_rst) begin rst = 1'b1; d_miss = 1'b0; end
            if (act_rst >= 0 && c == act_rst + 1) rst = 1'b0;
            if (c == act_raise_d) d_miss = 1'b1;
            if (c == act_raise_wr) d_wr_req = 1'b1;
            @(negedge clk);
            c_en[c] = mem_en;     c_wr[c] = mem_wr;   c_addr[c] = mem_addr;
            c_wdata[c] = mem_wdata; c_done[c] = d_wr_done;
            c_fs[c] = fetch_stall; c_ms[c] = mem_stall;
            c_fwi[c] = fill_we_i; c_fwd[c] = fill_we_d;
            c_fword[c] = fill_word; c_fdata[c] = fill_data;
            c_twi[c] = tag_we_i;  c_twd[c] = tag_we_d;
            pend_d = tag_we_d; pend_i = auto_i && tag_we_i; pend_wr = d_wr_done;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_miss = 0; d_miss = 0; d_wr_req = 0;
        i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        act_drop_d = -1; act_rst = -1; act_raise_d = -1; act_raise_wr = -1;
        auto_i = 1;
        repeat (MEM_LAT + 2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic int count_bits(input bit v[NC], input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) s += int'(v[c]);
        return s;
    endfunction

    initial begin
        // ---- reset state: outputs 0, stalls follow their inputs ----
        do_reset();
        rst = 1'b1; i_miss = 1'b1; d_wr_req = 1'b1; #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_done", d_wr_done, 0);
        check("rst_fill_base", fill_base, 0);
        check("rst_tag_we_i", tag_we_i, 0);
        check("rst_fetch_stall", fetch_stall, 1);
        check("rst_mem_stall", mem_stall, 1);
        $display("reset: outputs idle, stalls follow inputs");

        // ---- D fill ----
        do_reset();
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        @(posedge clk); #1;
        capture(15);
        check("dfill_base", fill_base, 16'h1230);
        for (int c = 0; c < 8; c++) begin
            check("dfill_req_en", c_en[c] & ~c_wr[c], 1);
            check("dfill_req_addr", c_addr[c], 16'h1230 + 2 * c);
            check("dfill_we_d", c_fwd[c + 4], 1);
            check("dfill_word", c_fword[c + 4], c);
            check("dfill_data", c_fdata[c + 4], 16'h1230 + 2 * c);
            check("dfill_stall", c_ms[c + 4], (c + 4 < 12) ? 1 : 0);
        end
        check("dfill_we_d_count", count_bits(c_fwd, 0, 14), 8);
        check("dfill_we_i_count", count_bits(c_fwi, 0, 14), 0);
        check("dfill_req_count", count_bits(c_en, 0, 14), 8);
        check("dfill_tag_c12", c_twd[12], 1);
        check("dfill_tag_count", count_bits(c_twd, 0, 14), 1);
        check("dfill_stall_c12", c_ms[12], 0);
        $display("d_fill: addr=1236 base=1230 tag_we_d at cycle 12");

        // ---- I fill ----
        do_reset();
        i_miss = 1'b1; i_miss_addr = 16'h0008;
        @(posedge clk); #1;
        capture(15);
        check("ifill_req0_addr", c_addr[0], 16'h0000);
        check("ifill_req7_addr", c_addr[7], 16'h000E);
        check("ifill_we_i_count", count_bits(c_fwi, 0, 14), 8);
        check("ifill_we_d_count", count_bits(c_fwd, 0, 14), 0);
        check("ifill_word7_data", c_fdata[11], 16'h000E);
        check("ifill_stall_c11", c_fs[11], 1);
        check("ifill_tag_c12", c_twi[12], 1);
        check("ifill_stall_c12", c_fs[12], 0);
        $display("i_fill: addr=0008 base=0000 tag_we_i at cycle 12");

        // ---- contention: D first, I starts right after ----
        do_reset();
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        i_miss = 1'b1; i_miss_addr = 16'h0008;
        @(posedge clk); #1;
        capture(30);
        check("cont_tag_d_c12", c_twd[12], 1);
        check("cont_idle_c13", c_en[13], 0);
        check("cont_i_req_c14", c_en[14] & ~c_wr[14], 1);
        check("cont_i_addr_c14", c_addr[14], 16'h0000);
        check("cont_we_i_first_c18", c_fwi[18], 1);
        check("cont_we_i_count", count_bits(c_fwi, 0, 29), 8);
        check("cont_tag_i_c26", c_twi[26], 1);
        check("cont_idle_c27", c_en[27], 0);
        $display("contention: d tag cycle 12, i tag cycle 26, idle cycle 27");

        // ---- store while idle ----
        do_reset();
        d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; #1;
        check("st_stall_idle", mem_stall, 1);
        @(posedge clk); #1;
        capture(3);
        check("st_en", c_en[0], 1);
        check("st_wr", c_wr[0], 1);
        check("st_addr", c_addr[0], 16'h0040);
        check("st_wdata", c_wdata[0], 16'hBEEF);
        check("st_done", c_done[0], 1);
        check("st_stall_done", c_ms[0], 0);
        check("st_done_c1", c_done[1], 0);
        check("st_en_c1", c_en[1], 0);
        $display("store: 0040 <- beef accepted in one cycle");

        // ---- store during I fill, served before a pending i_miss ----
        do_reset();
        i_miss = 1'b1; i_miss_addr = 16'h0008;
        d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
        auto_i = 0; act_raise_wr = 3;
        @(posedge clk); #1;
        capture(18);
        check("stf_stall_c3", c_ms[3], 1);
        check("stf_no_write_fill", count_bits(c_wr, 0, 12), 0);
        check("stf_tag_i_c12", c_twi[12], 1);
        check("stf_write_c14", c_en[14] & c_wr[14], 1);
        check("stf_done_c14", c_done[14], 1);
        check("stf_i_refill_c16", c_en[16] & ~c_wr[16], 1);
        $display("store during i_fill: write at cycle 14, i refill at 16");

        // ---- reset mid D fill ----
        do_reset();
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        act_rst = 6; act_raise_d = 12;
        @(posedge clk); #1;
        capture(22);
        check("rmf_word1_c5", c_fword[5], 1);
        check("rmf_en_c6", c_en[6], 0);
        check("rmf_stray_we", count_bits(c_fwd, 6, 16), 0);
        check("rmf_no_tag", count_bits(c_twd, 0, 21), 0);
        check("rmf_refill_addr_c13", c_addr[13], 16'h1230);
        check("rmf_refill_we_c17", c_fwd[17], 1);
        check("rmf_refill_word_c17", c_fword[17], 0);
        check("rmf_refill_data_c17", c_fdata[17], 16'h1230);
        $display("reset mid-fill: strays ignored, refill from word 0");

        // ---- flush: d_miss drops mid-fill ----
        do_reset();
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        act_drop_d = 3;
        @(posedge clk); #1;
        capture(15);
        check("fl_stall_c3", c_ms[3], 0);
        check("fl_we_d_count", count_bits(c_fwd, 0, 14), 8);
        check("fl_tag_c12", c_twd[12], 1);
        $display("flush: fill completes, tag_we_d at cycle 12");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
